muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Iterative radix-2 multiply/divide sequencer that owns the HI/LO register pair for the EX stage of the five-stage MIPS pipeline. It accepts one operation per start pulse, executes it over 33 cycles with a single shared 32-bit adder, and reports `busy` to the hazard/stall unit. Same-cycle interrupt requests cancel a start. An operation already in flight always completes.

## Interface
Parameters: none (fixed 32-bit datapath, 32 iterations).

- `clk` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high; clears all state.
- `start` input 1: single-cycle launch strobe from the EX stage.
- `op` input 3: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- `a` input 32: rs operand, already forwarded.
- `b` input 32: rt operand, already forwarded.
- `cancel` input 1: interrupt/exception request; suppresses a launch in the same cycle.
- `busy` output 1: high while an iterative op is in progress.
- `hi` output 32: HI register.
- `lo` output 32: LO register.

## Operation
- States: IDLE, RUN, FIX.
- IDLE -> RUN on `start && !cancel && op in {1..4}`.
  - Capture magnitudes |a| and |b|. Unsigned ops, and unsigned-op operand values, are taken as-is.
  - Capture sign flags: product/quotient sign = sa^sb; remainder sign = sa. Both flags are 0 for unsigned ops.
  - Clear the iteration counter to 0.
- Div/divu with b == 0: no launch. Stay IDLE; HI/LO unchanged; busy stays 0.
- RUN, one iteration per cycle; the counter increments 0..31.
  - Multiply: shift-add. Acc[63:0] starts as {32'b0, |a|}. Each cycle, if Acc[0], add |b| to Acc[63:32] with a 33-bit carry, then shift right by 1.
  - Divide: restoring. Rem starts at 0 and Q = |a|. Each cycle, shift {Rem,Q} left by 1 and trial-subtract |b| from Rem. If non-negative, keep the result and set Q[0]=1; else restore.
- RUN -> FIX after the iteration with counter == 31.
- FIX: apply signs.
  - Mult: write the 64-bit product, two's-complement negated if the sign flag is set; HI = [63:32], LO = [31:0].
  - Div: LO = quotient, negated if the sign flag is set; HI = remainder, negated if the remainder sign is set.
  - FIX -> IDLE.
- mthi/mtlo (op 5/6): with `start && !cancel && !busy`, HI or LO ← a at the clock edge. No state change, no busy.
- Ignored cases:
  - `start` while busy is ignored; the stall unit must not issue it.
  - `cancel` outside a launch cycle has no effect. An in-flight op is never aborted by `cancel`.
- Arithmetic:
  - 0x80000000 / -1 yields LO = 0x80000000, HI = 0 (no trap).
  - The magnitude of 0x80000000 is 0x80000000 as unsigned.

## Timing
- Reset: state IDLE, counter 0, busy 0, hi 0, lo 0, internal accumulators 0.
- Reset mid-operation returns to IDLE next edge and discards the result. HI/LO become 0.
- Launch at edge E0 (start sampled high):
  - busy = 1 from the cycle after E0 through the FIX cycle, 33 cycles total.
  - HI/LO hold the new result in the cycle after FIX (first cycle with busy = 0).
  - Total latency: 34 edges from the start edge.
- HI/LO hold their old values throughout RUN/FIX. They change only at the FIX edge, or at an mthi/mtlo edge.
- Stall contract: the stall unit stalls any mfhi/mflo/md op in ID while `busy || start`.
- Simultaneous events:
  - start+cancel: nothing launches and HI/LO are unchanged.
  - start in the cycle busy falls (IDLE again): accepted normally.

## Test plan
- Reset then multu a=0xFFFFFFFF, b=0xFFFFFFFF -> busy high 33 cycles; then hi=0xFFFFFFFE, lo=0x00000001.
- mult a=-3 (0xFFFFFFFD), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then div a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. divu a=100, b=0 -> busy stays 0, hi/lo unchanged.
- mthi a=0x12345678, then mtlo a=0x9ABCDEF0 on consecutive cycles -> hi/lo updated each next edge, busy never asserted. mthi asserted with busy=1 -> ignored.
- start=1, cancel=1, op=mult -> busy stays 0, hi/lo unchanged. Then cancel pulse at RUN cycle 10 of a divu 100/7 -> completes with lo=14, hi=2.
- reset asserted at RUN cycle 15 of a multu -> next cycle busy=0, hi=lo=0. New divu 1000/10 launched immediately after -> lo=100, hi=0.

Source files
------------

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_seq
//  Description : Iterative radix-2 multiply/divide sequencer owning HI/LO.
//                One op per start pulse: 32 RUN iterations through a single
//                shared adder, then one FIX cycle to apply signs.
//  Ports       : clk, reset (sync, active-high)
//                start, op[2:0], a[31:0], b[31:0], cancel  -- launch inputs
//                busy                                      -- stall request
//                hi[31:0], lo[31:0]                        -- HI/LO registers
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    state_t      state;
    state_t      state_next;

    // Multiply: acc = {partial product high, multiplier/low product}.
    // Divide:   acc = {remainder, dividend shifting into quotient}.
    logic [63:0] acc;
    logic [31:0] bmag;
    logic [4:0]  count;
    logic        is_div;
    logic        neg_res;
    logic        neg_rem;

    // ------------------------------------------------------------------
    // Launch decode
    // ------------------------------------------------------------------
    logic        is_mul_op;
    logic        is_div_op;
    logic        is_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        launch;
    logic        move_ok;

    assign is_mul_op = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div_op = (op == OP_DIV)  || (op == OP_DIVU);
    assign is_signed = (op == OP_MULT) || (op == OP_DIV);
    assign a_neg     = is_signed & a[31];
    assign b_neg     = is_signed & b[31];
    // 0x80000000 negates to itself, which is its correct unsigned magnitude.
    assign a_mag     = a_neg ? (32'd0 - a) : a;
    assign b_mag     = b_neg ? (32'd0 - b) : b;

    // Divide by zero never launches, leaving HI/LO untouched.
    assign launch  = start && !cancel && (state == IDLE) &&
                     (is_mul_op || (is_div_op && (b != 32'd0)));
    assign move_ok = start && !cancel && (state == IDLE);

    assign busy = (state != IDLE);

    // ------------------------------------------------------------------
    // Shared adder: add for multiply, trial-subtract for divide.
    // Divide operand is the remainder already shifted left with the next
    // dividend bit (acc[63:31]); the extra top bit gives the borrow/sign.
    // ------------------------------------------------------------------
    logic [33:0] add_x;
    logic [33:0] add_y;
    logic [33:0] sum;

    assign add_x = is_div ? {1'b0, acc[63:31]} : {2'b00, acc[63:32]};
    assign add_y = is_div ? ~{2'b00, bmag}     : {2'b00, bmag};
    assign sum   = add_x + add_y + {33'd0, is_div};

    logic [63:0] prod_neg;
    assign prod_neg = 64'd0 - acc;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (launch) state_next = RUN;
            RUN:     if (count == 5'd31) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Datapath and HI/LO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= 64'd0;
            bmag    <= 32'd0;
            count   <= 5'd0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (launch) begin
                        acc     <= {32'd0, a_mag};
                        bmag    <= b_mag;
                        count   <= 5'd0;
                        is_div  <= is_div_op;
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                    end else if (move_ok && (op == OP_MTHI)) begin
                        hi <= a;
                    end else if (move_ok && (op == OP_MTLO)) begin
                        lo <= a;
                    end
                end
                RUN: begin
                    count <= count + 5'd1;
                    if (is_div) begin
                        if (!sum[33]) begin
                            acc <= {sum[31:0], acc[30:0], 1'b1};
                        end else begin
                            acc <= {acc[62:0], 1'b0};
                        end
                    end else begin
                        if (acc[0]) begin
                            acc <= {sum[32:0], acc[31:1]};
                        end else begin
                            acc <= {1'b0, acc[63:1]};
                        end
                    end
                end
                FIX: begin
                    if (is_div) begin
                        lo <= neg_res ? (32'd0 - acc[31:0])  : acc[31:0];
                        hi <= neg_rem ? (32'd0 - acc[63:32]) : acc[63:32];
                    end else begin
                        lo <= neg_res ? prod_neg[31:0]  : acc[31:0];
                        hi <= neg_res ? prod_neg[63:32] : acc[63:32];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_seq
//  Description : Directed self-checking bench for muldiv_seq.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int total;
    int passed;
    int failed;
    int cycles;

    muldiv_seq dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle; returns at the negedge after the start edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        op    = 3'd0;
    endtask

    // Counts negedges with busy high, bounded.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        total  = 0;
        passed = 0;
        failed = 0;
        reset  = 1'b1;
        start  = 1'b0;
        cancel = 1'b0;
        op     = 3'd0;
        a      = 32'd0;
        b      = 32'd0;

        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);

        // multu max*max
        issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_idle(cycles);
        chk("multu_busy_cycles", cycles, 33);
        chk("multu_hi", hi, 32'hFFFFFFFE);
        chk("multu_lo", lo, 32'h00000001);

        // mult -3 * 7 = -21
        issue(3'd1, 32'hFFFFFFFD, 32'd7);
        wait_idle(cycles);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFEB);

        // div -7 / 2 = -3 rem -1
        issue(3'd3, 32'hFFFFFFF9, 32'd2);
        wait_idle(cycles);
        chk("div_cycles", cycles, 33);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);

        // div INT_MIN / -1 wraps without trap
        issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(cycles);
        chk("divmin_lo", lo, 32'h80000000);
        chk("divmin_hi", hi, 32'h00000000);

        // divu by zero: no launch
        issue(3'd4, 32'd100, 32'd0);
        chk("div0_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("div0_lo", lo, 32'h80000000);
        chk("div0_hi", hi, 32'h00000000);

        // mthi then mtlo on consecutive cycles
        @(negedge clk);
        start = 1'b1;
        op    = 3'd5;
        a     = 32'h12345678;
        @(negedge clk);
        chk("mthi_hi", hi, 32'h12345678);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        op = 3'd6;
        a  = 32'h9ABCDEF0;
        @(negedge clk);
        start = 1'b0;
        op    = 3'd0;
        chk("mtlo_lo", lo, 32'h9ABCDEF0);
        chk("mtlo_hi", hi, 32'h12345678);
        chk("mtlo_busy", {31'd0, busy}, 32'd0);

        // start with cancel: nothing launches
        @(negedge clk);
        start  = 1'b1;
        cancel = 1'b1;
        op     = 3'd1;
        a      = 32'd3;
        b      = 32'd5;
        @(negedge clk);
        start  = 1'b0;
        cancel = 1'b0;
        op     = 3'd0;
        chk("cancel_busy", {31'd0, busy}, 32'd0);
        chk("cancel_hi", hi, 32'h12345678);
        chk("cancel_lo", lo, 32'h9ABCDEF0);

        // divu 100/7 with an mthi while busy and a cancel pulse mid-run
        issue(3'd4, 32'd100, 32'd7);
        chk("divu_launch_busy", {31'd0, busy}, 32'd1);
        repeat (4) @(negedge clk);
        start = 1'b1;
        op    = 3'd5;
        a     = 32'hDEADBEEF;
        @(negedge clk);
        start = 1'b0;
        op    = 3'd0;
        chk("mthi_while_busy", hi, 32'h12345678);
        repeat (5) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_inflight_busy", {31'd0, busy}, 32'd1);
        wait_idle(cycles);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);

        // reset mid-multu, then immediate divu
        issue(3'd2, 32'd5, 32'd6);
        repeat (15) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_hi", hi, 32'd0);
        chk("midreset_lo", lo, 32'd0);
        issue(3'd4, 32'd1000, 32'd10);
        wait_idle(cycles);
        chk("divu2_cycles", cycles, 33);
        chk("divu2_lo", lo, 32'd100);
        chk("divu2_hi", hi, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
